mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_beat_counter.sv | 30 +++
 rtl/mem_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the off-chip memory arbiter: FSM state/grant encodings and default burst length.
// The state encoding doubles as the grant code driven to the pins.
package mem_arb_pkg;

  localparam int BEATS_DEF = 4;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I_RD = 2'b01;
  localparam logic [1:0] GNT_D_RD = 2'b10;
  localparam logic [1:0] GNT_D_WR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = GNT_NONE,
    ST_I_RD = GNT_I_RD,
    ST_D_RD = GNT_D_RD,
    ST_D_WR = GNT_D_WR
  } arb_state_t;

endpackage

// File: rtl/arb_beat_counter.sv
// Burst beat counter: counts accepted read words, flags the final beat combinationally.
// Latency: done is same-cycle with the last inc; count wraps to 0 on that edge.
// Backpressure: only advances when inc (memory rdrdy and granted acceptance) is high.
module arb_beat_counter
  import mem_arb_pkg::*;
#(
  parameter int BEATS = BEATS_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(BEATS)-1:0] count,
  output logic                     done
);

  localparam int CW = $clog2(BEATS);

  assign done = inc && (count == CW'(BEATS - 1));

  // BEATS is a power of two, so the natural rollover is the burst wrap
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the off-chip memory bus between I-cache reads and D-cache reads/writes.
// Latency: grant registered one edge after IDLE arbitration; one IDLE cycle between grants.
// Backpressure: memory handshakes reach only the granted cache. ARB_RR_EN selects D/I round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BEATS = BEATS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_rrqst,
  input  logic             i_rdacpt,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             i_rrdy,
  output logic             i_rdrdy,
  input  logic             d_rrqst,
  input  logic             d_wrqst,
  input  logic             d_rdacpt,
  input  logic             d_oe,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_rrdy,
  output logic             d_rdrdy,
  output logic             d_wacpt,
  output logic [WIDTH-1:0] rdata,
  output logic             rrqst,
  output logic             wrqst,
  output logic             rdacpt,
  input  logic             rrdy,
  input  logic             rdrdy,
  input  logic             wacpt,
  inout  wire  [WIDTH-1:0] offdata,
  output logic [1:0]       grant
);

  localparam int CW = $clog2(BEATS);

  arb_state_t    state;
  logic          seen;
  logic [CW-1:0] count;
  logic          is_i, is_drd, is_dwr;
  logic          drive, hs, inc, done, abandon, pick_d, clr;

  assign is_i   = (state == ST_I_RD);
  assign is_drd = (state == ST_D_RD);
  assign is_dwr = (state == ST_D_WR);
  assign grant  = state;

  assign rrqst  = (is_i & i_rrqst) | (is_drd & d_rrqst);
  assign wrqst  = is_dwr & d_wrqst;
  assign rdacpt = (is_i & i_rdacpt) | (is_drd & d_rdacpt);

  assign i_rrdy  = is_i & rrdy;
  assign i_rdrdy = is_i & rdrdy;
  assign d_rrdy  = is_drd & rrdy;
  assign d_rdrdy = is_drd & rdrdy;
  assign d_wacpt = is_dwr & wacpt;

  assign drive   = (is_i & i_rrqst) | ((is_drd | is_dwr) & d_oe);
  assign offdata = drive ? (is_i ? i_wdata : d_wdata) : 'z;
  assign rdata   = offdata;

  // The memory has committed once it answers; after that the grant is held to completion
  assign hs      = ((is_i | is_drd) & rrdy) | (is_dwr & wacpt);
  assign inc     = (is_i | is_drd) & rdrdy & rdacpt;
  assign abandon = ~(rrqst | wrqst) & (count == '0) & ~seen & ~hs & ~inc;
  assign clr     = (state == ST_IDLE);

`ifdef ARB_RR_EN
  logic last_d;
  assign pick_d = (d_wrqst | d_rrqst) & (~i_rrqst | ~last_d);
`else
  assign pick_d = d_wrqst | d_rrqst;
`endif

  arb_beat_counter #(.BEATS(BEATS)) u_beats (
    .clock (clock),
    .reset (reset),
    .inc   (inc),
    .clr   (clr),
    .count (count),
    .done  (done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      seen   <= 1'b0;
`ifdef ARB_RR_EN
      last_d <= 1'b0;
`endif
    end else begin
      seen <= (state != ST_IDLE) & (seen | hs);
      case (state)
        ST_IDLE: begin
          if (pick_d) begin
            state  <= d_wrqst ? ST_D_WR : ST_D_RD;
`ifdef ARB_RR_EN
            last_d <= 1'b1;
`endif
          end else if (i_rrqst) begin
            state  <= ST_I_RD;
`ifdef ARB_RR_EN
            last_d <= 1'b0;
`endif
          end
        end
        ST_D_WR: if (wacpt | abandon) state <= ST_IDLE;
        default: if (done | abandon) state <= ST_IDLE;
      endcase
    end
  end

endmodule
